// File: rtl/cp0_tlb_param.sv
//------------------------------------------------------------------------------
// cp0_tlb_param : CP0 register file for the TLB-enabled MIPS core
//   (TLB index/data, exceptions, prescaled timer, interrupt request)
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module cp0_tlb_param #(
  parameter int TLBNUM  = 16,
  parameter int CNT_DIV = 2,
  localparam int IW     = $clog2(TLBNUM)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [5:0]    ext_int,
  input  logic          mtc0_we,
  input  logic [7:0]    cp0_addr,
  input  logic [31:0]   cp0_wdata,
  output logic [31:0]   cp0_rdata,
  input  logic          excp_valid,
  input  logic [4:0]    excp_code,
  input  logic          excp_bd,
  input  logic [31:0]   excp_pc,
  input  logic [31:0]   excp_badvaddr,
  input  logic          eret,
  input  logic          tlbp_we,
  input  logic          tlbp_found,
  input  logic [IW-1:0] tlbp_index,
  input  logic          tlbr_we,
  input  logic [18:0]   r_vpn2,
  input  logic [7:0]    r_asid,
  input  logic          r_g,
  input  logic [19:0]   r_pfn0,
  input  logic [2:0]    r_c0,
  input  logic          r_d0,
  input  logic          r_v0,
  input  logic [19:0]   r_pfn1,
  input  logic [2:0]    r_c1,
  input  logic          r_d1,
  input  logic          r_v1,
  input  logic          tlbwr,
  output logic [IW-1:0] r_index,
  output logic [IW-1:0] w_index,
  output logic [18:0]   w_vpn2,
  output logic [7:0]    w_asid,
  output logic          w_g,
  output logic [19:0]   w_pfn0,
  output logic [2:0]    w_c0,
  output logic          w_d0,
  output logic          w_v0,
  output logic [19:0]   w_pfn1,
  output logic [2:0]    w_c1,
  output logic          w_d1,
  output logic          w_v1,
  output logic [31:0]   epc,
  output logic          status_exl,
  output logic          int_req
);

  localparam int PW = (CNT_DIV > 1) ? $clog2(CNT_DIV) : 1;
  localparam logic [IW-1:0] RAND_MAX = IW'(TLBNUM - 1);
  localparam logic [PW-1:0] PRE_MAX  = PW'(CNT_DIV - 1);

  localparam logic [7:0] A_INDEX    = 8'h00;
  localparam logic [7:0] A_RANDOM   = 8'h08;
  localparam logic [7:0] A_ENTRYLO0 = 8'h10;
  localparam logic [7:0] A_ENTRYLO1 = 8'h18;
  localparam logic [7:0] A_CONTEXT  = 8'h20;
  localparam logic [7:0] A_WIRED    = 8'h30;
  localparam logic [7:0] A_BADVADDR = 8'h40;
  localparam logic [7:0] A_COUNT    = 8'h48;
  localparam logic [7:0] A_ENTRYHI  = 8'h50;
  localparam logic [7:0] A_COMPARE  = 8'h58;
  localparam logic [7:0] A_STATUS   = 8'h60;
  localparam logic [7:0] A_CAUSE    = 8'h68;
  localparam logic [7:0] A_EPC      = 8'h70;

  logic          index_p_q, index_p_d;
  logic [IW-1:0] index_q, index_d, random_q, random_d, wired_q, wired_d;
  logic [8:0]    ptebase_q, ptebase_d;
  logic [18:0]   badvpn2_q, badvpn2_d, ehi_vpn2_q, ehi_vpn2_d;
  logic [7:0]    ehi_asid_q, ehi_asid_d;
  logic [19:0]   lo0_pfn_q, lo0_pfn_d, lo1_pfn_q, lo1_pfn_d;
  logic [2:0]    lo0_c_q, lo0_c_d, lo1_c_q, lo1_c_d;
  logic          lo0_d_q, lo0_d_d, lo0_v_q, lo0_v_d, lo0_g_q, lo0_g_d;
  logic          lo1_d_q, lo1_d_d, lo1_v_q, lo1_v_d, lo1_g_q, lo1_g_d;
  logic [31:0]   badvaddr_q, badvaddr_d, count_q, count_d;
  logic [31:0]   compare_q, compare_d, epc_q, epc_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    im_q, im_d, ip_q, ip_d;
  logic          exl_q, exl_d, ie_q, ie_d, bd_q, bd_d, ti_q, ti_d;
  logic [4:0]    exccode_q, exccode_d;

  always_comb begin
    index_p_d  = index_p_q;  index_d    = index_q;
    wired_d    = wired_q;    ptebase_d  = ptebase_q;
    badvpn2_d  = badvpn2_q;  ehi_vpn2_d = ehi_vpn2_q;
    ehi_asid_d = ehi_asid_q; badvaddr_d = badvaddr_q;
    lo0_pfn_d  = lo0_pfn_q;  lo0_c_d = lo0_c_q; lo0_d_d = lo0_d_q;
    lo0_v_d    = lo0_v_q;    lo0_g_d = lo0_g_q;
    lo1_pfn_d  = lo1_pfn_q;  lo1_c_d = lo1_c_q; lo1_d_d = lo1_d_q;
    lo1_v_d    = lo1_v_q;    lo1_g_d = lo1_g_q;
    compare_d  = compare_q;  epc_d   = epc_q;
    im_d       = im_q;       exl_d   = exl_q;   ie_d = ie_q;
    bd_d       = bd_q;       exccode_d = exccode_q;

    // Free-running state: Random, timer, and sampled interrupt pending bits
    random_d = (random_q <= wired_q) ? RAND_MAX : random_q - IW'(1);
    if (presc_q == PRE_MAX) begin
      presc_d = '0;
      count_d = count_q + 32'd1;
    end else begin
      presc_d = presc_q + PW'(1);
      count_d = count_q;
    end
    ti_d = ti_q | (count_q == compare_q);
    ip_d = {ext_int[5] | ti_q, ext_int[4:0], ip_q[1:0]};

    if (excp_valid) begin
      exl_d     = 1'b1;
      exccode_d = excp_code;
      if (!exl_q) begin
        epc_d = excp_bd ? excp_pc - 32'd4 : excp_pc;
        bd_d  = excp_bd;
      end
      if (excp_code >= 5'd1 && excp_code <= 5'd5) badvaddr_d = excp_badvaddr;
      if (excp_code >= 5'd1 && excp_code <= 5'd3) begin
        ehi_vpn2_d = excp_badvaddr[31:13];
        badvpn2_d  = excp_badvaddr[31:13];
      end
    end else if (eret) begin
      exl_d = 1'b0;
    end else if (mtc0_we) begin
      case (cp0_addr)
        A_INDEX:    index_d = cp0_wdata[IW-1:0];
        A_ENTRYLO0: {lo0_pfn_d, lo0_c_d, lo0_d_d, lo0_v_d, lo0_g_d} = cp0_wdata[25:0];
        A_ENTRYLO1: {lo1_pfn_d, lo1_c_d, lo1_d_d, lo1_v_d, lo1_g_d} = cp0_wdata[25:0];
        A_CONTEXT:  ptebase_d = cp0_wdata[31:23];
        A_WIRED: begin
          wired_d  = cp0_wdata[IW-1:0];
          random_d = RAND_MAX;
        end
        A_COUNT: begin
          count_d = cp0_wdata;
          presc_d = '0;
        end
        A_ENTRYHI: begin
          ehi_vpn2_d = cp0_wdata[31:13];
          ehi_asid_d = cp0_wdata[7:0];
        end
        A_COMPARE: begin
          compare_d = cp0_wdata;
          ti_d      = 1'b0;
        end
        A_STATUS: begin
          im_d  = cp0_wdata[15:8];
          exl_d = cp0_wdata[1];
          ie_d  = cp0_wdata[0];
        end
        A_CAUSE:    ip_d[1:0] = cp0_wdata[9:8];
        A_EPC:      epc_d = cp0_wdata;
        default: ;
      endcase
    end else begin
      if (tlbp_we) begin
        index_p_d = !tlbp_found;
        index_d   = tlbp_index;
      end
      if (tlbr_we) begin
        ehi_vpn2_d = r_vpn2;
        ehi_asid_d = r_asid;
        {lo0_pfn_d, lo0_c_d, lo0_d_d, lo0_v_d, lo0_g_d} = {r_pfn0, r_c0, r_d0, r_v0, r_g};
        {lo1_pfn_d, lo1_c_d, lo1_d_d, lo1_v_d, lo1_g_d} = {r_pfn1, r_c1, r_d1, r_v1, r_g};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      index_p_q <= 1'b0;  index_q <= '0;  random_q <= RAND_MAX;  wired_q <= '0;
      ptebase_q <= '0;    badvpn2_q <= '0; ehi_vpn2_q <= '0;     ehi_asid_q <= '0;
      lo0_pfn_q <= '0; lo0_c_q <= '0; lo0_d_q <= 1'b0; lo0_v_q <= 1'b0; lo0_g_q <= 1'b0;
      lo1_pfn_q <= '0; lo1_c_q <= '0; lo1_d_q <= 1'b0; lo1_v_q <= 1'b0; lo1_g_q <= 1'b0;
      badvaddr_q <= '0;   count_q <= '0;  compare_q <= '0;  epc_q <= '0;
      presc_q <= '0;      im_q <= '0;     ip_q <= '0;
      exl_q <= 1'b0;      ie_q <= 1'b0;   bd_q <= 1'b0;     ti_q <= 1'b0;
      exccode_q <= '0;
    end else begin
      index_p_q <= index_p_d; index_q <= index_d; random_q <= random_d; wired_q <= wired_d;
      ptebase_q <= ptebase_d; badvpn2_q <= badvpn2_d;
      ehi_vpn2_q <= ehi_vpn2_d; ehi_asid_q <= ehi_asid_d;
      lo0_pfn_q <= lo0_pfn_d; lo0_c_q <= lo0_c_d; lo0_d_q <= lo0_d_d;
      lo0_v_q <= lo0_v_d; lo0_g_q <= lo0_g_d;
      lo1_pfn_q <= lo1_pfn_d; lo1_c_q <= lo1_c_d; lo1_d_q <= lo1_d_d;
      lo1_v_q <= lo1_v_d; lo1_g_q <= lo1_g_d;
      badvaddr_q <= badvaddr_d; count_q <= count_d; compare_q <= compare_d; epc_q <= epc_d;
      presc_q <= presc_d; im_q <= im_d; ip_q <= ip_d;
      exl_q <= exl_d; ie_q <= ie_d; bd_q <= bd_d; ti_q <= ti_d;
      exccode_q <= exccode_d;
    end
  end

  always_comb begin
    cp0_rdata = 32'd0;
    case (cp0_addr)
      A_INDEX:    cp0_rdata = {index_p_q, 31'(index_q)};
      A_RANDOM:   cp0_rdata = 32'(random_q);
      A_ENTRYLO0: cp0_rdata = {6'b0, lo0_pfn_q, lo0_c_q, lo0_d_q, lo0_v_q, lo0_g_q};
      A_ENTRYLO1: cp0_rdata = {6'b0, lo1_pfn_q, lo1_c_q, lo1_d_q, lo1_v_q, lo1_g_q};
      A_CONTEXT:  cp0_rdata = {ptebase_q, badvpn2_q, 4'b0};
      A_WIRED:    cp0_rdata = 32'(wired_q);
      A_BADVADDR: cp0_rdata = badvaddr_q;
      A_COUNT:    cp0_rdata = count_q;
      A_ENTRYHI:  cp0_rdata = {ehi_vpn2_q, 5'b0, ehi_asid_q};
      A_COMPARE:  cp0_rdata = compare_q;
      A_STATUS:   cp0_rdata = {9'b0, 1'b1, 6'b0, im_q, 6'b0, exl_q, ie_q};
      A_CAUSE:    cp0_rdata = {bd_q, ti_q, 14'b0, ip_q, 1'b0, exccode_q, 2'b0};
      A_EPC:      cp0_rdata = epc_q;
      default:    cp0_rdata = 32'd0;
    endcase
  end

  assign r_index    = index_q;
  assign w_index    = tlbwr ? random_q : index_q;
  assign w_vpn2     = ehi_vpn2_q;
  assign w_asid     = ehi_asid_q;
  assign w_g        = lo0_g_q & lo1_g_q;
  assign w_pfn0     = lo0_pfn_q;
  assign w_c0       = lo0_c_q;
  assign w_d0       = lo0_d_q;
  assign w_v0       = lo0_v_q;
  assign w_pfn1     = lo1_pfn_q;
  assign w_c1       = lo1_c_q;
  assign w_d1       = lo1_d_q;
  assign w_v1       = lo1_v_q;
  assign epc        = epc_q;
  assign status_exl = exl_q;
  assign int_req    = ie_q & !exl_q & |(ip_q & im_q);

endmodule

`default_nettype wire

// File: tb/tb_cp0_tlb_param.sv
//------------------------------------------------------------------------------
// tb_cp0_tlb_param : directed self-checking bench for cp0_tlb_param
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_cp0_tlb_param;
  localparam int TLBNUM = 16;
  localparam int IW     = 4;

  logic clk = 1'b0;
  logic reset;
  logic [5:0]  ext_int;
  logic        mtc0_we;
  logic [7:0]  cp0_addr;
  logic [31:0] cp0_wdata, cp0_rdata;
  logic        excp_valid, excp_bd, eret;
  logic [4:0]  excp_code;
  logic [31:0] excp_pc, excp_badvaddr;
  logic        tlbp_we, tlbp_found, tlbr_we, tlbwr;
  logic [IW-1:0] tlbp_index, r_index, w_index;
  logic [18:0] r_vpn2, w_vpn2;
  logic [7:0]  r_asid, w_asid;
  logic        r_g, w_g;
  logic [19:0] r_pfn0, r_pfn1, w_pfn0, w_pfn1;
  logic [2:0]  r_c0, r_c1, w_c0, w_c1;
  logic        r_d0, r_v0, r_d1, r_v1, w_d0, w_v0, w_d1, w_v1;
  logic [31:0] epc;
  logic        status_exl, int_req;

  int checks = 0;
  int errors = 0;
  logic [31:0] v;

  always #10 clk = ~clk;

  cp0_tlb_param #(.TLBNUM(TLBNUM), .CNT_DIV(2)) dut (
    .clk(clk), .reset(reset), .ext_int(ext_int), .mtc0_we(mtc0_we),
    .cp0_addr(cp0_addr), .cp0_wdata(cp0_wdata), .cp0_rdata(cp0_rdata),
    .excp_valid(excp_valid), .excp_code(excp_code), .excp_bd(excp_bd),
    .excp_pc(excp_pc), .excp_badvaddr(excp_badvaddr), .eret(eret),
    .tlbp_we(tlbp_we), .tlbp_found(tlbp_found), .tlbp_index(tlbp_index),
    .tlbr_we(tlbr_we), .r_vpn2(r_vpn2), .r_asid(r_asid), .r_g(r_g),
    .r_pfn0(r_pfn0), .r_c0(r_c0), .r_d0(r_d0), .r_v0(r_v0),
    .r_pfn1(r_pfn1), .r_c1(r_c1), .r_d1(r_d1), .r_v1(r_v1),
    .tlbwr(tlbwr), .r_index(r_index), .w_index(w_index),
    .w_vpn2(w_vpn2), .w_asid(w_asid), .w_g(w_g),
    .w_pfn0(w_pfn0), .w_c0(w_c0), .w_d0(w_d0), .w_v0(w_v0),
    .w_pfn1(w_pfn1), .w_c1(w_c1), .w_d1(w_d1), .w_v1(w_v1),
    .epc(epc), .status_exl(status_exl), .int_req(int_req)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d);
    cp0_addr = a;
    #1;
    d = cp0_rdata;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    cp0_addr  = a;
    cp0_wdata = d;
    mtc0_we   = 1'b1;
    step();
    mtc0_we   = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [31:0] rnd_exp [6];
    rnd_exp = '{32'd14, 32'd13, 32'd12, 32'd15, 32'd14, 32'd13};

    reset = 1'b1; ext_int = '0; mtc0_we = 1'b0; cp0_addr = '0; cp0_wdata = '0;
    excp_valid = 1'b0; excp_code = '0; excp_bd = 1'b0; excp_pc = '0; excp_badvaddr = '0;
    eret = 1'b0; tlbp_we = 1'b0; tlbp_found = 1'b0; tlbp_index = '0; tlbr_we = 1'b0;
    r_vpn2 = '0; r_asid = '0; r_g = 1'b0; r_pfn0 = '0; r_c0 = '0; r_d0 = 1'b0; r_v0 = 1'b0;
    r_pfn1 = '0; r_c1 = '0; r_d1 = 1'b0; r_v1 = 1'b0; tlbwr = 1'b0;
    step(); step();

    // Reset state
    rd(8'h08, v); chk("reset_random", v, 32'd15);
    rd(8'h60, v); chk("reset_status", v, 32'h0040_0000);
    rd(8'h68, v); chk("reset_cause", v, 32'h0);
    chk("reset_int_req", 32'(int_req), 32'd0);
    chk("reset_w_index", 32'(w_index), 32'd0);
    chk("reset_epc", epc, 32'h0);
    chk("reset_exl", 32'(status_exl), 32'd0);

    reset = 1'b0;
    step(); rd(8'h08, v); chk("random_dec1", v, 32'd14);
    step(); rd(8'h08, v); chk("random_dec2", v, 32'd13);

    // Wired = 12, with read-after-write returning the old value
    cp0_addr = 8'h30; cp0_wdata = 32'd12; mtc0_we = 1'b1;
    #1; chk("wired_raw_old", cp0_rdata, 32'd0);
    step(); mtc0_we = 1'b0;
    rd(8'h30, v); chk("wired_val", v, 32'd12);
    rd(8'h08, v); chk("random_after_wired", v, 32'd15);
    for (int i = 0; i < 6; i++) begin
      step();
      rd(8'h08, v); chk($sformatf("random_seq%0d", i), v, rnd_exp[i]);
    end

    // Wired = TLBNUM-1 pins Random
    wr(8'h30, 32'd15);
    for (int i = 0; i < 3; i++) begin
      rd(8'h08, v); chk($sformatf("random_hold%0d", i), v, 32'd15);
      step();
    end

    // Timer: Count=0, Compare=4, CNT_DIV=2
    wr(8'h48, 32'd0);
    wr(8'h58, 32'd4);
    rd(8'h68, v); chk("ti_cleared_by_compare", 32'(v[30]), 32'd0);
    for (int i = 0; i < 7; i++) step();
    rd(8'h48, v); chk("count_after_8", v, 32'd4);
    rd(8'h68, v); chk("ti_not_yet", 32'(v[30]), 32'd0);
    step();
    rd(8'h68, v); chk("ti_set", 32'(v[30]), 32'd1);
    rd(8'h48, v); chk("count_held_prescale", v, 32'd4);
    wr(8'h60, 32'h0000_8001);
    rd(8'h60, v); chk("status_im7_ie", v, 32'h0040_8001);
    chk("int_req_timer", 32'(int_req), 32'd1);
    wr(8'h58, 32'h0000_0100);
    rd(8'h68, v); chk("ti_clear", 32'(v[30]), 32'd0);
    step();
    chk("int_req_timer_off", 32'(int_req), 32'd0);

    // Count wrap
    wr(8'h48, 32'hFFFF_FFFF);
    step();
    rd(8'h48, v); chk("count_max", v, 32'hFFFF_FFFF);
    step();
    rd(8'h48, v); chk("count_wrap", v, 32'h0);
    wr(8'h60, 32'h0);

    // Exception in delay slot collides with MTC0 EPC: exception wins
    excp_valid = 1'b1; excp_code = 5'd2; excp_bd = 1'b1;
    excp_pc = 32'h8000_1004; excp_badvaddr = 32'h0040_2ABC;
    cp0_addr = 8'h70; cp0_wdata = 32'hDEAD_BEEF; mtc0_we = 1'b1;
    step();
    excp_valid = 1'b0; mtc0_we = 1'b0;
    rd(8'h70, v); chk("excp_epc_reg", v, 32'h8000_1000);
    chk("excp_epc_port", epc, 32'h8000_1000);
    chk("excp_exl", 32'(status_exl), 32'd1);
    rd(8'h68, v); chk("excp_bd", 32'(v[31]), 32'd1);
    chk("excp_code", 32'(v[6:2]), 32'd2);
    rd(8'h40, v); chk("excp_badvaddr", v, 32'h0040_2ABC);
    rd(8'h50, v); chk("excp_entryhi", v, 32'h0040_2000);
    rd(8'h20, v); chk("excp_context", v, 32'h0000_2010);

    // Nested exception leaves EPC/BD, code 0 leaves BadVAddr
    excp_valid = 1'b1; excp_code = 5'd0; excp_bd = 1'b0;
    excp_pc = 32'h8000_2000; excp_badvaddr = 32'h1111_1111;
    step();
    excp_valid = 1'b0;
    chk("nested_epc", epc, 32'h8000_1000);
    rd(8'h68, v); chk("nested_bd", 32'(v[31]), 32'd1);
    chk("nested_code", 32'(v[6:2]), 32'd0);
    rd(8'h40, v); chk("nested_badvaddr", v, 32'h0040_2ABC);
    eret = 1'b1; step(); eret = 1'b0;
    chk("eret_exl", 32'(status_exl), 32'd0);

    // TLBP
    tlbp_we = 1'b1; tlbp_found = 1'b0; tlbp_index = 4'd0;
    step();
    rd(8'h00, v); chk("tlbp_miss", v, 32'h8000_0000);
    tlbp_found = 1'b1; tlbp_index = 4'd9;
    step();
    tlbp_we = 1'b0;
    rd(8'h00, v); chk("tlbp_hit", v, 32'h0000_0009);
    chk("r_index", 32'(r_index), 32'd9);

    // TLBR
    tlbr_we = 1'b1; r_vpn2 = 19'h12345; r_asid = 8'h5A; r_g = 1'b1;
    r_pfn0 = 20'h12345; r_c0 = 3'd2; r_d0 = 1'b1; r_v0 = 1'b1;
    r_pfn1 = 20'h0ABCD; r_c1 = 3'd3; r_d1 = 1'b0; r_v1 = 1'b1;
    step();
    tlbr_we = 1'b0;
    rd(8'h10, v); chk("tlbr_lo0", v, 32'h0048_D157);
    rd(8'h18, v); chk("tlbr_lo1", v, 32'h002A_F35B);
    rd(8'h50, v); chk("tlbr_entryhi", v, 32'h2468_A05A);
    chk("w_g_set", 32'(w_g), 32'd1);
    chk("w_pfn0", 32'(w_pfn0), 32'h12345);
    chk("w_vpn2", 32'(w_vpn2), 32'h12345);

    // Write index selection
    tlbwr = 1'b0; #1; chk("w_index_index", 32'(w_index), 32'd9);
    tlbwr = 1'b1; #1; chk("w_index_random", 32'(w_index), 32'd15);
    tlbwr = 1'b0;
    wr(8'h10, 32'h0000_0006);
    chk("w_g_clear", 32'(w_g), 32'd0);

    // Hardware interrupt with one-cycle latency
    wr(8'h60, 32'h0000_0801);
    ext_int = 6'b000010;
    #1; chk("ext_int_before_edge", 32'(int_req), 32'd0);
    step();
    chk("ext_int_req", 32'(int_req), 32'd1);
    rd(8'h68, v); chk("ext_int_ip3", 32'(v[15:8]), 32'h08);

    // Unmapped addresses
    rd(8'h28, v); chk("unmapped_28", v, 32'h0);
    rd(8'h09, v); chk("unmapped_sel1", v, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
